// File: rtl/ccg_pkg.sv
// Shared definitions for the response compactor: FSM state encoding and
// default widths/constants for the MISR and the group-consistency check.
package ccg_pkg;

  localparam int unsigned OUT_W_DEF = 30;
  localparam int unsigned SIG_W_DEF = 32;

  localparam logic [SIG_W_DEF-1:0] POLY_DEF     = 32'h04C11DB7;
  localparam logic [SIG_W_DEF-1:0] SEED_DEF     = 32'hFFFFFFFF;
  // bit=1 marks group-B bits (must track resp[7]), bit=0 marks group-A bits (must track resp[0])
  localparam logic [OUT_W_DEF-1:0] GRP_MASK_DEF = 30'h1F4F9780;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } ccg_state_t;

endpackage

// File: rtl/ccg_misr_step.sv
// One MISR step: shift the signature left, fold in the feedback polynomial
// when the outgoing MSB is set, and XOR in the zero-extended response.
module ccg_misr_step
  import ccg_pkg::*;
#(
  parameter int unsigned           OUT_W = OUT_W_DEF,
  parameter int unsigned           SIG_W = SIG_W_DEF,
  parameter logic [SIG_W-1:0]      POLY  = POLY_DEF
) (
  input  logic [SIG_W-1:0] sig_cur,
  input  logic [OUT_W-1:0] resp,
  output logic [SIG_W-1:0] sig_next
);

  // Next-signature function
  always_comb begin
    sig_next = {sig_cur[SIG_W-2:0], 1'b0}
             ^ (sig_cur[SIG_W-1] ? POLY : '0)
             ^ {{(SIG_W-OUT_W){1'b0}}, resp};
  end

endmodule

// File: rtl/ccg_resp_compactor.sv
// Response compactor: accepts num_vec response vectors, compacts them into a
// MISR signature, tracks a sticky group-consistency error and hands the
// final signature over with a valid/ready handshake.
module ccg_resp_compactor
  import ccg_pkg::*;
#(
  parameter int unsigned      OUT_W    = OUT_W_DEF,
  parameter int unsigned      SIG_W    = SIG_W_DEF,
  parameter logic [SIG_W-1:0] POLY     = POLY_DEF,
  parameter logic [SIG_W-1:0] SEED     = SEED_DEF,
  parameter logic [OUT_W-1:0] GRP_MASK = GRP_MASK_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [15:0]      num_vec,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OUT_W-1:0] resp,
  output logic             sig_valid,
  input  logic             sig_ready,
  output logic [SIG_W-1:0] sig,
  output logic [15:0]      vec_cnt,
  output logic             grp_err,
  output logic             busy
);

  ccg_state_t state, state_next;

  logic [15:0]      num_lat;
  logic [SIG_W-1:0] sig_step;
  logic             load;
  logic             accept;
  logic             last;
  logic             grp_bad;
  logic [OUT_W-1:0] a_dev;
  logic [OUT_W-1:0] b_dev;

  ccg_misr_step #(
    .OUT_W (OUT_W),
    .SIG_W (SIG_W),
    .POLY  (POLY)
  ) u_misr_step (
    .sig_cur  (sig),
    .resp     (resp),
    .sig_next (sig_step)
  );

  // Group check: group-A bits must equal resp[0], group-B bits must equal resp[7]
  always_comb begin
    a_dev   = ~GRP_MASK & (resp ^ {OUT_W{resp[0]}});
    b_dev   =  GRP_MASK & (resp ^ {OUT_W{resp[7]}});
    grp_bad = (|a_dev) | (|b_dev);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic and handshake outputs
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    sig_valid  = 1'b0;
    busy       = 1'b0;
    load       = 1'b0;
    accept     = 1'b0;
    last       = (vec_cnt == (num_lat - 16'd1));
    unique case (state)
      S_IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = (num_vec == 16'd0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        accept   = in_valid;
        if (in_valid && last) state_next = S_DONE;
      end
      S_DONE: begin
        sig_valid = 1'b1;
        busy      = 1'b1;
        // start in the same cycle as sig_ready is deliberately dropped
        if (sig_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Run datapath: signature, vector count, sticky error, latched length
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig     <= SEED;
      vec_cnt <= '0;
      grp_err <= 1'b0;
      num_lat <= '0;
    end else if (load) begin
      sig     <= SEED;
      vec_cnt <= '0;
      grp_err <= 1'b0;
      num_lat <= num_vec;
    end else if (accept) begin
      sig     <= sig_step;
      vec_cnt <= vec_cnt + 16'd1;
      grp_err <= grp_err | grp_bad;
    end
  end

endmodule

// File: tb/tb_ccg_resp_compactor.sv
// Directed testbench for ccg_resp_compactor with hand-computed signatures.
module tb_ccg_resp_compactor;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] num_vec;
  logic        in_valid;
  logic        in_ready;
  logic [29:0] resp;
  logic        sig_valid;
  logic        sig_ready;
  logic [31:0] sig;
  logic [15:0] vec_cnt;
  logic        grp_err;
  logic        busy;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] sig_hold;

  always #5 clk = ~clk;

  ccg_resp_compactor dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num_vec   (num_vec),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .resp      (resp),
    .sig_valid (sig_valid),
    .sig_ready (sig_ready),
    .sig       (sig),
    .vec_cnt   (vec_cnt),
    .grp_err   (grp_err),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Outputs expected in IDLE / after reset
  task automatic check_idle(input string tag, input logic [31:0] s, input logic [15:0] c, input logic e);
    check({tag, "_in_ready"},  64'(in_ready),  64'd0);
    check({tag, "_sig_valid"}, 64'(sig_valid), 64'd0);
    check({tag, "_busy"},      64'(busy),      64'd0);
    check({tag, "_sig"},       64'(sig),       64'(s));
    check({tag, "_vec_cnt"},   64'(vec_cnt),   64'(c));
    check({tag, "_grp_err"},   64'(grp_err),   64'(e));
  endtask

  task automatic check_done(input string tag, input logic [31:0] s, input logic [15:0] c, input logic e);
    check({tag, "_in_ready"},  64'(in_ready),  64'd0);
    check({tag, "_sig_valid"}, 64'(sig_valid), 64'd1);
    check({tag, "_busy"},      64'(busy),      64'd1);
    check({tag, "_sig"},       64'(sig),       64'(s));
    check({tag, "_vec_cnt"},   64'(vec_cnt),   64'(c));
    check({tag, "_grp_err"},   64'(grp_err),   64'(e));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; num_vec = '0; in_valid = 1'b0; resp = '0; sig_ready = 1'b0;
    tick(); tick();
    check_idle("reset", 32'hFFFFFFFF, 16'd0, 1'b0);
    rst = 1'b0;

    // in_valid while idle is ignored
    in_valid = 1'b1; resp = 30'h3FFFFFFF;
    tick();
    check_idle("idle_valid", 32'hFFFFFFFF, 16'd0, 1'b0);
    in_valid = 1'b0;

    // Single vector of zeros
    start = 1'b1; num_vec = 16'd1;
    tick();
    start = 1'b0;
    check("nv1_in_ready", 64'(in_ready), 64'd1);
    check("nv1_busy", 64'(busy), 64'd1);
    in_valid = 1'b1; resp = 30'h0;
    tick();
    in_valid = 1'b0;
    check_done("nv1", 32'hFB3EE249, 16'd1, 1'b0);
    sig_ready = 1'b1;
    tick();
    sig_ready = 1'b0;
    check_idle("nv1_idle", 32'hFB3EE249, 16'd1, 1'b0);

    // Zero-length run goes straight to DONE with the seed
    start = 1'b1; num_vec = 16'd0;
    tick();
    start = 1'b0;
    check_done("nv0", 32'hFFFFFFFF, 16'd0, 1'b0);
    sig_ready = 1'b1;
    tick();
    sig_ready = 1'b0;
    check_idle("nv0_idle", 32'hFFFFFFFF, 16'd0, 1'b0);

    // Three consistent vectors with in_valid gaps
    start = 1'b1; num_vec = 16'd3;
    tick();
    start = 1'b0;
    resp = 30'h1F4F9780;
    in_valid = 1'b1; tick();
    check("nv3_cnt1", 64'(vec_cnt), 64'd1);
    check("nv3_sig1", 64'(sig), 64'h00000000E47175C9);
    in_valid = 1'b0; tick();
    check("nv3_gap_cnt", 64'(vec_cnt), 64'd1);
    check("nv3_gap_sig", 64'(sig), 64'h00000000E47175C9);
    in_valid = 1'b1; start = 1'b1; tick();
    start = 1'b0;
    check("nv3_cnt2", 64'(vec_cnt), 64'd2);
    check("nv3_sig2", 64'(sig), 64'h00000000D36C61A5);
    check("nv3_run_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b0; tick();
    in_valid = 1'b1; tick();
    in_valid = 1'b0;
    check_done("nv3", 32'hBD56497D, 16'd3, 1'b0);

    // Hold DONE without sig_ready while pulsing start and in_valid
    for (int unsigned i = 0; i < 10; i++) begin
      start = i[0]; in_valid = ~i[0]; num_vec = 16'd5;
      tick();
      check_done("hold", 32'hBD56497D, 16'd3, 1'b0);
    end
    // start together with sig_ready: only return to IDLE
    start = 1'b1; sig_ready = 1'b1; in_valid = 1'b0;
    tick();
    start = 1'b0; sig_ready = 1'b0;
    check_idle("drop_start", 32'hBD56497D, 16'd3, 1'b0);
    tick();
    check_idle("drop_start2", 32'hBD56497D, 16'd3, 1'b0);

    // Group error on the second vector stays sticky into IDLE
    start = 1'b1; num_vec = 16'd2;
    tick();
    start = 1'b0;
    check("ge_cleared", 64'(grp_err), 64'd0);
    in_valid = 1'b1; resp = 30'h0; tick();
    check("ge_first_ok", 64'(grp_err), 64'd0);
    resp = 30'h00000001; tick();
    in_valid = 1'b0;
    check_done("ge", 32'hF2BCD924, 16'd2, 1'b1);
    sig_ready = 1'b1; tick(); sig_ready = 1'b0;
    check_idle("ge_idle", 32'hF2BCD924, 16'd2, 1'b1);
    start = 1'b1; num_vec = 16'd1; tick(); start = 1'b0;
    check("ge_new_start", 64'(grp_err), 64'd0);
    check("ge_new_sig", 64'(sig), 64'h00000000FFFFFFFF);
    in_valid = 1'b1; resp = 30'h0; tick(); in_valid = 1'b0;
    sig_ready = 1'b1; tick(); sig_ready = 1'b0;

    // Asynchronous reset after 2 of 5 accepts
    start = 1'b1; num_vec = 16'd5; tick(); start = 1'b0;
    in_valid = 1'b1; resp = 30'h0; tick(); tick();
    in_valid = 1'b0;
    check("mid_cnt", 64'(vec_cnt), 64'd2);
    #2 rst = 1'b1;
    #1;
    check_idle("async_rst", 32'hFFFFFFFF, 16'd0, 1'b0);
    tick();
    rst = 1'b0;
    start = 1'b1; num_vec = 16'd1; tick(); start = 1'b0;
    check("post_rst_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b1; resp = 30'h0; tick(); in_valid = 1'b0;
    check_done("post_rst", 32'hFB3EE249, 16'd1, 1'b0);
    sig_ready = 1'b1; tick(); sig_ready = 1'b0;
    check_idle("post_rst_idle", 32'hFB3EE249, 16'd1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
